// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-control bundle between the five-stage core
// datapath and hazard_ctrl.
//   Inputs to the controller : decode/execute/memory/writeback register
//                              indices, load/branch/write flags and the
//                              data-memory request/ready handshake.
//   Outputs from controller  : per-stage stall/flush enables, execute
//                              operand forwarding selects, the sticky
//                              memory watchdog error and the two
//                              performance counters.
//   master : datapath side (drives the pipeline state, receives controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  logic [4:0]       RS1_E;
  logic [4:0]       RS2_E;
  logic [4:0]       RD_E;
  logic             ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RD_M;
  logic             RegWriteM;
  logic             MemReqM;
  logic             dmem_ready;
  logic [4:0]       RD_W;
  logic             RegWriteW;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE, PCSrcE,
           RD_M, RegWriteM, MemReqM, dmem_ready, RD_W, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE, PCSrcE,
           RD_M, RegWriteM, MemReqM, dmem_ready, RD_W, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the five-stage RISC-V core.
// Drives stall/flush enables of the F/D/E/M pipeline registers, selects
// execute-stage operand forwarding, holds the pipeline idle for a boot
// window after reset and freezes it while data memory is waiting, with a
// sticky watchdog error.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   hz  : hazard_ctrl_if.slave bundle (pipeline indices/flags in,
//         stall/flush/forward controls, mem_err and counters out)
// Parameters:
//   BOOT_CYCLES : cycles held in INIT after reset release (min 1)
//   MEM_TIMEOUT : consecutive wait cycles before mem_err (min 1)
//   CNT_W       : performance counter width
module hazard_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [BOOT_W-1:0] boot_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic              lw_hazard;
  logic              mem_wait;
  logic              boot_done;
  logic              active;

  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              stall_m;
  logic              flush_d;
  logic              flush_e;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  // ---------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------
  assign lw_hazard = hz.ResultSrcE && (hz.RD_E != 5'd0) &&
                     ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
  assign mem_wait  = hz.MemReqM && !hz.dmem_ready;
  assign boot_done = (boot_cnt == BOOT_LAST);
  assign active    = (state != S_INIT);

  // ---------------------------------------------------------------------
  // Operand forwarding: memory stage has priority over writeback, x0 never
  // forwards. Independent of the FSM state.
  // ---------------------------------------------------------------------
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && (hz.RD_M != 5'd0) && (hz.RD_M == hz.RS1_E))
      fwd_a = 2'b10;
    else if (hz.RegWriteW && (hz.RD_W != 5'd0) && (hz.RD_W == hz.RS1_E))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RD_M != 5'd0) && (hz.RD_M == hz.RS2_E))
      fwd_b = 2'b10;
    else if (hz.RegWriteW && (hz.RD_W != 5'd0) && (hz.RD_W == hz.RS2_E))
      fwd_b = 2'b01;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_INIT;
    else
      state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_INIT:     if (boot_done) state_nxt = S_RUN;
      S_RUN:      if (mem_wait)  state_nxt = S_MEM_WAIT;
      // Watchdog never forces an exit; only the ready handshake leaves.
      S_MEM_WAIT: if (!mem_wait) state_nxt = S_RUN;
      default:    state_nxt = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: Mealy outputs. RUN and MEM_WAIT share one priority chain: in
  // MEM_WAIT the wait term wins while memory is still busy, and the ready
  // cycle falls through to the normal RUN rules, so a one-cycle wait
  // costs exactly one frozen cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    unique case (state)
      S_INIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      S_RUN, S_MEM_WAIT: begin
        if (mem_wait) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
        end else if (hz.PCSrcE) begin
          // Taken branch discards the load consumer, so no load stall.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lw_hazard) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      default: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Boot counter, watchdog and performance counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_cnt    <= '0;
      wait_cnt    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((state == S_INIT) && !boot_done)
        boot_cnt <= boot_cnt + BOOT_W'(1);

      // The RUN cycle that first sees the wait counts as wait cycle one.
      if (active && mem_wait) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt >= WAIT_TRIP)
          mem_err_q <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (active && stall_f && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);

      if (flush_d && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.ForwardAE = fwd_a;
  assign hz.ForwardBE = fwd_b;
  assign hz.mem_err   = mem_err_q;
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural model of the controller.
module tb_hazard_ctrl;

  localparam int unsigned BOOT = 4;
  localparam int unsigned TO   = 5;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();

  hazard_ctrl #(
    .BOOT_CYCLES (BOOT),
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: remaining boot cycles, length of the current run of
  // consecutive memory-wait cycles, sticky error and the two counts.
  int boot_left;
  int wait_run;
  int err;
  int scnt;
  int fcnt;
  int burst = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_sel(input logic rw_m, input logic [4:0] rd_m,
                                 input logic rw_w, input logic [4:0] rd_w,
                                 input logic [4:0] rs);
    if (rs == 5'd0)                return 0;
    if (rw_m && rd_m == rs)        return 2;
    if (rw_w && rd_w == rs)        return 1;
    return 0;
  endfunction

  task automatic model_reset();
    boot_left = BOOT;
    wait_run  = 0;
    err       = 0;
    scnt      = 0;
    fcnt      = 0;
  endtask

  task automatic idle_in();
    hif.RS1_D      = 5'd0;
    hif.RS2_D      = 5'd0;
    hif.RS1_E      = 5'd0;
    hif.RS2_E      = 5'd0;
    hif.RD_E       = 5'd0;
    hif.ResultSrcE = 1'b0;
    hif.PCSrcE     = 1'b0;
    hif.RD_M       = 5'd0;
    hif.RegWriteM  = 1'b0;
    hif.MemReqM    = 1'b0;
    hif.dmem_ready = 1'b0;
    hif.RD_W       = 5'd0;
    hif.RegWriteW  = 1'b0;
  endtask

  task automatic rand_in();
    hif.RS1_D      = 5'($urandom_range(0, 3));
    hif.RS2_D      = 5'($urandom_range(0, 3));
    hif.RS1_E      = 5'($urandom_range(0, 3));
    hif.RS2_E      = 5'($urandom_range(0, 3));
    hif.RD_E       = 5'($urandom_range(0, 3));
    hif.ResultSrcE = ($urandom_range(0, 2) == 0);
    hif.PCSrcE     = ($urandom_range(0, 4) == 0);
    hif.RD_M       = 5'($urandom_range(0, 3));
    hif.RegWriteM  = ($urandom_range(0, 1) == 0);
    hif.RD_W       = 5'($urandom_range(0, 3));
    hif.RegWriteW  = ($urandom_range(0, 1) == 0);
    if (burst == 0 && $urandom_range(0, 59) == 0)
      burst = $urandom_range(3, 8);
    if (burst > 0) begin
      burst--;
      hif.MemReqM    = 1'b1;
      hif.dmem_ready = 1'b0;
    end else begin
      hif.MemReqM    = ($urandom_range(0, 2) == 0);
      hif.dmem_ready = ($urandom_range(0, 1) == 0);
    end
  endtask

  // Called at posedge+1 with inputs already applied; checks the cycle at the
  // falling edge, advances the model and returns at the next posedge+1.
  task automatic cycle();
    int mw, lw, sf, sd, se, sm, fd, fe;
    @(negedge clk);
    mw = int'(hif.MemReqM && !hif.dmem_ready);
    lw = int'(hif.ResultSrcE && hif.RD_E != 5'd0 &&
              (hif.RD_E == hif.RS1_D || hif.RD_E == hif.RS2_D));
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0;
    if (rst || boot_left > 0) begin
      sf = 1; sd = 1; fe = 1;
    end else if (mw != 0) begin
      sf = 1; sd = 1; se = 1; sm = 1;
    end else if (hif.PCSrcE) begin
      fd = 1; fe = 1;
    end else if (lw != 0) begin
      sf = 1; sd = 1; fe = 1;
    end
    check("StallF", 32'(hif.StallF), sf);
    check("StallD", 32'(hif.StallD), sd);
    check("StallE", 32'(hif.StallE), se);
    check("StallM", 32'(hif.StallM), sm);
    check("FlushD", 32'(hif.FlushD), fd);
    check("FlushE", 32'(hif.FlushE), fe);
    check("ForwardAE", 32'(hif.ForwardAE),
          fwd_sel(hif.RegWriteM, hif.RD_M, hif.RegWriteW, hif.RD_W, hif.RS1_E));
    check("ForwardBE", 32'(hif.ForwardBE),
          fwd_sel(hif.RegWriteM, hif.RD_M, hif.RegWriteW, hif.RD_W, hif.RS2_E));
    check("mem_err", 32'(hif.mem_err), err);
    check("stall_cnt", 32'(hif.stall_cnt), scnt);
    check("flush_cnt", 32'(hif.flush_cnt), fcnt);
    if (rst) begin
      model_reset();
    end else if (boot_left > 0) begin
      boot_left--;
    end else begin
      wait_run = (mw != 0) ? wait_run + 1 : 0;
      if (wait_run >= int'(TO)) err = 1;
      if (sf != 0 && scnt < CMAX) scnt++;
      if (fd != 0 && fcnt < CMAX) fcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts rst in the middle of a cycle, checks the asynchronous response,
  // holds it across one edge and releases it.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_StallF", 32'(hif.StallF), 1);
    check("rst_StallD", 32'(hif.StallD), 1);
    check("rst_FlushE", 32'(hif.FlushE), 1);
    check("rst_StallE", 32'(hif.StallE), 0);
    check("rst_StallM", 32'(hif.StallM), 0);
    check("rst_FlushD", 32'(hif.FlushD), 0);
    check("rst_mem_err", 32'(hif.mem_err), 0);
    check("rst_stall_cnt", 32'(hif.stall_cnt), 0);
    check("rst_flush_cnt", 32'(hif.flush_cnt), 0);
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  task automatic boot_idle();
    idle_in();
    for (int i = 0; i < int'(BOOT) + 2; i++) cycle();
  endtask

  initial begin
    idle_in();
    model_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Boot window then idle; stall_cnt must stay 0.
    boot_idle();
    check("boot_stall_cnt", 32'(hif.stall_cnt), 0);

    // Load-use stall, then forwarding from the memory stage.
    hif.ResultSrcE = 1'b1; hif.RD_E = 5'd5; hif.RS2_D = 5'd5;
    cycle();
    idle_in();
    hif.RD_M = 5'd5; hif.RegWriteM = 1'b1; hif.RS2_E = 5'd5;
    cycle();
    check("lw_ForwardBE", 32'(hif.ForwardBE), 2);
    check("lw_stall_cnt", 32'(hif.stall_cnt), 1);

    // Branch flush dominates the load hazard.
    pulse_reset();
    boot_idle();
    hif.ResultSrcE = 1'b1; hif.RD_E = 5'd5; hif.RS2_D = 5'd5; hif.PCSrcE = 1'b1;
    cycle();
    idle_in();
    cycle();
    check("br_flush_cnt", 32'(hif.flush_cnt), 1);
    check("br_stall_cnt", 32'(hif.stall_cnt), 0);

    // Forwarding priority and x0.
    hif.RD_M = 5'd7; hif.RD_W = 5'd7; hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
    hif.RS1_E = 5'd7;
    cycle();
    check("fwd_mem", 32'(hif.ForwardAE), 2);
    hif.RD_M = 5'd0;
    cycle();
    check("fwd_wb", 32'(hif.ForwardAE), 1);
    hif.RS1_E = 5'd0;
    cycle();
    check("fwd_x0", 32'(hif.ForwardAE), 0);

    // Three-cycle memory wait with a branch pulse mid-wait.
    pulse_reset();
    boot_idle();
    hif.MemReqM = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hif.PCSrcE = (i == 1);
      cycle();
    end
    hif.PCSrcE = 1'b0; hif.dmem_ready = 1'b1;
    cycle();
    idle_in();
    cycle();
    check("wait_stall_cnt", 32'(hif.stall_cnt), 3);
    check("wait_flush_cnt", 32'(hif.flush_cnt), 0);

    // Watchdog timeout, then reset in the middle of the wait.
    pulse_reset();
    boot_idle();
    hif.MemReqM = 1'b1; hif.dmem_ready = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    check("to_mem_err", 32'(hif.mem_err), 1);
    pulse_reset();
    boot_idle();
    check("to_mem_err_clr", 32'(hif.mem_err), 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if ($urandom_range(0, 399) == 0)
        pulse_reset();
      else
        cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage RISC-V core. It drives the stall and flush enables of the fetch, decode, execute and memory pipeline registers, and selects execute-stage operand forwarding. It holds the pipeline idle for a boot window after reset and freezes the pipeline on data-memory wait with a watchdog. It sits beside the decode/execute boundary and consumes register indices and control bits already carried down the pipeline.

Parameters:
BOOT_CYCLES, 4, cycles after reset release during which fetch is held and bubbles are injected (min 1)
MEM_TIMEOUT, 255, consecutive data-memory wait cycles before mem_err is raised
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
RS1_D  in  5  decode source register 1 (InstrD[19:15])
RS2_D  in  5  decode source register 2 (InstrD[24:20])
RS1_E  in  5  execute source register 1
RS2_E  in  5  execute source register 2
RD_E  in  5  execute destination register
ResultSrcE  in  1  execute instruction is a load
PCSrcE  in  1  execute branch/jump taken
RD_M  in  5  memory-stage destination register
RegWriteM  in  1  memory-stage register write
MemReqM  in  1  memory-stage data-memory access active
dmem_ready  in  1  data memory completes access this cycle
RD_W  in  5  writeback destination register
RegWriteW  in  1  writeback register write
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register (bubble)
ForwardAE  out  2  operand A select: 00 register file, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  operand B select, same encoding
mem_err  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles with StallF=1 outside INIT
flush_cnt  out  CNT_W  cycles with a branch flush applied

Behaviour:
- Forwarding, combinational, all states: ForwardAE=10 if RegWriteM and RD_M!=0 and RD_M==RS1_E; else 01 if RegWriteW and RD_W!=0 and RD_W==RS1_E; else 00. Memory stage has priority over writeback. ForwardBE is identical, using RS2_E.
- lw_hazard = ResultSrcE and RD_E!=0 and (RD_E==RS1_D or RD_E==RS2_D).
- mem_wait = MemReqM and not dmem_ready.
- States: INIT, RUN, MEM_WAIT. Outputs are Mealy, combinational from state and inputs.
- INIT: StallF=StallD=1, FlushE=1, all others 0. Boot counter increments each cycle. After BOOT_CYCLES cycles in INIT, go to RUN.
- RUN, priority high to low:
  - mem_wait: StallF=StallD=StallE=StallM=1, no flush, next state MEM_WAIT.
  - PCSrcE: FlushD=FlushE=1, no stall. The branch flush dominates lw_hazard because the consumer is discarded.
  - lw_hazard: StallF=StallD=1, FlushE=1.
  - Otherwise all stall/flush outputs are 0.
- MEM_WAIT:
  - While mem_wait: all four stalls are 1, and PCSrcE and lw_hazard are ignored. The wait counter increments, saturating at MEM_TIMEOUT.
  - On reaching MEM_TIMEOUT, mem_err is set. It stays set until rst. The stall continues; there is no forced exit.
  - When dmem_ready=1: outputs follow the RUN rules in that same cycle, the wait counter clears, and the next state is RUN.
- A single-cycle wait (ready on the next cycle) costs exactly one frozen cycle.
- stall_cnt increments on every cycle with StallF=1 in RUN or MEM_WAIT. flush_cnt increments on every cycle PCSrcE causes FlushD. Both saturate at all-ones.
- Reset, asynchronous, any time including mid-wait:
  - state=INIT; boot and wait counters 0; mem_err=0; stall_cnt=flush_cnt=0.
  - Outputs while rst is high: StallF=StallD=1, FlushE=1, StallE=StallM=FlushD=0. Forward outputs follow their combinational rule.
- Register x0 never triggers a hazard or forwarding.

Test Plan:
- Reset release with BOOT_CYCLES=4 -> StallF=FlushE=1 for exactly 4 cycles, then 0; stall_cnt stays 0.
- Load x5 in E (ResultSrcE=1, RD_E=5), RS2_D=5 -> one cycle of StallF=StallD=FlushE=1; the next cycle (RD_M=5, RegWriteM=1, RS2_E=5) gives ForwardBE=10; stall_cnt=1.
- Same as the previous case but PCSrcE=1 -> FlushD=FlushE=1, StallF=0; flush_cnt=1, stall_cnt=0.
- RD_M=RD_W=7 with both writes set, RS1_E=7 -> ForwardAE=10. With RD_M=0 instead -> ForwardAE=01. With RS1_E=0 -> 00.
- MemReqM=1, dmem_ready low for 3 cycles -> all stalls=1 for 3 cycles, and PCSrcE pulsed mid-wait produces no flush. Ready in cycle 4 -> stalls drop that cycle; stall_cnt=3.
- MEM_TIMEOUT=5, ready held low for 8 cycles -> mem_err rises after the 5th wait cycle and stays high. Asserting rst mid-wait clears mem_err and the counters and returns to INIT.
